// File: rtl/input_pack_mem.sv
// rtl/input_pack_mem.sv - byte-stream packer writing 128-bit words into a frame buffer
// Optional build macro PARTIAL_FLUSH_EN: on abort, write any partial word MSB-aligned and zero-padded.
module input_pack_mem #(
    parameter int WORDS_PER_FRAME = 19200,
    parameter int BYTES_PER_WORD  = 16,
    parameter int BUS_WIDTH       = 128,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  StartIn,
    input  logic [7:0]            DataIn,
    input  logic                  input_base_offset,
    output logic [ADDR_WIDTH-1:0] WriteAddress,
    output logic [BUS_WIDTH-1:0]  WriteBus,
    output logic                  WriteEnable,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

    localparam logic [ADDR_WIDTH-2:0] LAST_IDX = (ADDR_WIDTH-1)'(WORDS_PER_FRAME - 1);
`ifdef PARTIAL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    state_t                state;
    logic [BUS_WIDTH-1:0]  acc;
    logic [3:0]            byte_cnt;
    logic [ADDR_WIDTH-2:0] word_idx;
    logic                  base;

    logic [BUS_WIDTH-1:0]  acc_next;
    logic [4:0]            cnt_next;
    logic [7:0]            shamt;
    logic [BUS_WIDTH-1:0]  aligned_word;
    logic                  word_full;

    // Bytes shift in at the bottom; the left shift lifts them to the MSBs and
    // drops stale bytes from the previous group, so a full word needs no shift.
    always_comb begin
        acc_next     = StartIn ? {acc[BUS_WIDTH-9:0], DataIn} : acc;
        cnt_next     = {1'b0, byte_cnt} + {4'b0000, StartIn};
        shamt        = {5'(BYTES_PER_WORD) - cnt_next, 3'b000};
        aligned_word = acc_next << shamt;
        word_full    = StartIn && (byte_cnt == 4'd15);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            byte_cnt     <= 4'd0;
            word_idx     <= '0;
            base         <= 1'b0;
            WriteAddress <= '0;
            WriteBus     <= '0;
            WriteEnable  <= 1'b0;
            done         <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            case (state)
                IDLE: begin
                    word_idx <= '0;
                    byte_cnt <= 4'd0;
                    base     <= input_base_offset;
                    done     <= 1'b0;
                    if (start) begin
                        state    <= PACK;
                        acc      <= acc_next;
                        byte_cnt <= {3'b000, StartIn};
                    end
                end
                PACK: begin
                    acc      <= acc_next;
                    byte_cnt <= cnt_next[3:0];
                    if (word_full || (!start && FLUSH_EN && cnt_next != 5'd0)) begin
                        WriteBus     <= aligned_word;
                        WriteAddress <= {base, word_idx};
                        WriteEnable  <= 1'b1;
                    end
                    if (word_full && word_idx != LAST_IDX)
                        word_idx <= word_idx + 1'b1;
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (word_full && word_idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_pack_mem.sv
// tb/tb_input_pack_mem.sv - randomized self-checking bench for input_pack_mem
`timescale 1ns/1ps
module tb_input_pack_mem;
    localparam int WPF = 24;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         StartIn = 1'b0;
    logic [7:0]   DataIn = 8'h00;
    logic         input_base_offset = 1'b0;
    logic [15:0]  WriteAddress;
    logic [127:0] WriteBus;
    logic         WriteEnable;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    logic [15:0]  wa_q[$];
    logic [127:0] wd_q[$];
    int           wc_q[$];
    logic [15:0]  ea_q[$];
    logic [127:0] ed_q[$];
    logic [7:0]   byte_q[$];
    logic         m_base;
    int           m_idx;
    bit           m_accept = 1'b0;

    input_pack_mem #(.WORDS_PER_FRAME(WPF)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .StartIn(StartIn),
        .DataIn(DataIn), .input_base_offset(input_base_offset),
        .WriteAddress(WriteAddress), .WriteBus(WriteBus),
        .WriteEnable(WriteEnable), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;
    always @(negedge clock) begin
        if (WriteEnable === 1'b1) begin
            wa_q.push_back(WriteAddress);
            wd_q.push_back(WriteBus);
            wc_q.push_back(cycle);
        end
    end

    function automatic logic [127:0] pack_group();
        logic [127:0] w = '0;
        for (int i = 0; i < byte_q.size(); i++) w[127-8*i -: 8] = byte_q[i];
        return w;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (!m_accept) return;
        byte_q.push_back(b);
        if (byte_q.size() == 16) begin
            ea_q.push_back({m_base, 15'(m_idx)});
            ed_q.push_back(pack_group());
            byte_q.delete();
            m_idx++;
            if (m_idx == WPF) m_accept = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        StartIn = 1'b1;
        DataIn = b;
        model_byte(b);
        step();
        StartIn = 1'b0;
    endtask

    task automatic clear_q();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        ea_q.delete(); ed_q.delete(); byte_q.delete();
    endtask

    task automatic begin_frame(input logic off);
        start = 1'b0;
        input_base_offset = off;
        step();
        clear_q();
        start = 1'b1;
        m_base = off;
        m_idx = 0;
        m_accept = 1'b1;
    endtask

    task automatic end_frame();
`ifdef PARTIAL_FLUSH_EN
        if (m_accept && byte_q.size() > 0) begin
            ea_q.push_back({m_base, 15'(m_idx)});
            ed_q.push_back(pack_group());
        end
`endif
        m_accept = 1'b0;
        byte_q.delete();
        start = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        checks += 4;
        if (WriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", WriteEnable); end
        if (WriteAddress !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0", WriteAddress); end
        if (WriteBus !== 128'h0) begin errors++; $display("FAIL reset_bus got %h want 0", WriteBus); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        reset_n = 1'b1;
        clear_q();
        step(); step(); step();
        checks++;
        if (wa_q.size() != 0) begin errors++; $display("FAIL idle_no_write got %0d writes want 0", wa_q.size()); end
    endtask

    task automatic test_single_word();
        int c15;
        begin_frame(1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        c15 = cycle;
        step(); step();
        end_frame();
        checks++;
        if (wa_q.size() != 1) begin
            errors++; $display("FAIL single_count got %0d want 1", wa_q.size());
        end else begin
            checks += 4;
            if (wa_q[0] !== 16'h8000) begin errors++; $display("FAIL single_addr got %h want 8000", wa_q[0]); end
            if (wd_q[0] !== 128'h000102030405060708090A0B0C0D0E0F) begin
                errors++; $display("FAIL single_data got %h want 000102030405060708090a0b0c0d0e0f", wd_q[0]);
            end
            if (wd_q[0] !== ed_q[0]) begin errors++; $display("FAIL single_model got %h want %h", wd_q[0], ed_q[0]); end
            if (wc_q[0] != c15) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", wc_q[0], c15); end
        end
    endtask

    task automatic test_gaps();
        begin_frame(1'b0);
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) send_byte(8'($urandom));
            else step();
        end
        end_frame();
        checks++;
        if (wa_q.size() != 2) begin
            errors++; $display("FAIL gaps_count got %0d want 2", wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks += 2;
                if (wa_q[i] !== 16'(i)) begin errors++; $display("FAIL gaps_addr%0d got %h want %h", i, wa_q[i], 16'(i)); end
                if (wd_q[i] !== ed_q[i]) begin errors++; $display("FAIL gaps_data%0d got %h want %h", i, wd_q[i], ed_q[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        begin_frame(1'($urandom));
        for (int i = 0; i < 48; i++) begin
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        end_frame();
        checks++;
        if (wa_q.size() != ea_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", wa_q.size(), ea_q.size());
        end else begin
            for (int i = 0; i < ea_q.size(); i++) begin
                checks += 2;
                if (wa_q[i] !== ea_q[i]) begin errors++; $display("FAIL b2b_addr%0d got %h want %h", i, wa_q[i], ea_q[i]); end
                if (wd_q[i] !== ed_q[i]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, wd_q[i], ed_q[i]); end
            end
        end
    endtask

    task automatic test_full_frame();
        int bad = 0;
        begin_frame(1'b0);
        for (int i = 0; i < WPF * 16; i++) begin
            send_byte(8'($urandom));
            if (i != WPF * 16 - 1 && $urandom_range(0, 7) == 0) step();
        end
        checks += 3;
        if (WriteEnable !== 1'b1) begin errors++; $display("FAIL last_we got %b want 1", WriteEnable); end
        if (WriteAddress !== 16'(WPF - 1)) begin errors++; $display("FAIL last_addr got %h want %h", WriteAddress, 16'(WPF - 1)); end
        if (done !== 1'b0) begin errors++; $display("FAIL done_early got %b want 0", done); end
        step();
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL done_set got %b want 1", done); end
        if (WriteEnable !== 1'b0) begin errors++; $display("FAIL we_width got %b want 0", WriteEnable); end
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        step();
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", done); end
        if (wa_q.size() != WPF) begin
            errors++; $display("FAIL frame_count got %0d want %0d", wa_q.size(), WPF);
        end else begin
            for (int i = 0; i < WPF; i++)
                if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL frame_words got %0d bad words want 0", bad); end
        end
        start = 1'b0;
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_clear got %b want 0", done); end
        end_frame();
    endtask

    task automatic test_abort();
        begin_frame(1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
        step();
        end_frame();
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
`ifdef PARTIAL_FLUSH_EN
        if (wa_q.size() != 2) begin
            errors++; $display("FAIL abort_count got %0d want 2", wa_q.size());
        end else begin
            checks += 3;
            if (wa_q[1] !== 16'h8001) begin errors++; $display("FAIL flush_addr got %h want 8001", wa_q[1]); end
            if (wd_q[1] !== 128'hAABBCCDDEE0000000000000000000000) begin
                errors++; $display("FAIL flush_data got %h want aabbccddee0000000000000000000000", wd_q[1]);
            end
            if (wd_q[0] !== ed_q[0]) begin errors++; $display("FAIL abort_word0 got %h want %h", wd_q[0], ed_q[0]); end
        end
`else
        if (wa_q.size() != 1) begin
            errors++; $display("FAIL abort_count got %0d want 1", wa_q.size());
        end else begin
            checks += 2;
            if (wa_q[0] !== 16'h8000) begin errors++; $display("FAIL abort_addr got %h want 8000", wa_q[0]); end
            if (wd_q[0] !== ed_q[0]) begin errors++; $display("FAIL abort_word0 got %h want %h", wd_q[0], ed_q[0]); end
        end
`endif
    endtask

    task automatic test_reset_midframe();
        begin_frame(1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        reset_n = 1'b0;
        m_accept = 1'b0;
        byte_q.delete();
        step();
        checks += 3;
        if (WriteEnable !== 1'b0) begin errors++; $display("FAIL midreset_we got %b want 0", WriteEnable); end
        if (WriteAddress !== 16'h0) begin errors++; $display("FAIL midreset_addr got %h want 0", WriteAddress); end
        if (WriteBus !== 128'h0) begin errors++; $display("FAIL midreset_bus got %h want 0", WriteBus); end
        reset_n = 1'b1;
        start = 1'b0;
        step(); step();
        checks++;
        if (wa_q.size() != 0) begin errors++; $display("FAIL midreset_nowrite got %0d want 0", wa_q.size()); end
        begin_frame(1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));
        end_frame();
        checks++;
        if (wa_q.size() != 1) begin
            errors++; $display("FAIL restart_count got %0d want 1", wa_q.size());
        end else begin
            checks += 2;
            if (wa_q[0] !== 16'h8000) begin errors++; $display("FAIL restart_addr got %h want 8000", wa_q[0]); end
            if (wd_q[0] !== ed_q[0]) begin errors++; $display("FAIL restart_data got %h want %h", wd_q[0], ed_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_back_to_back();
        test_full_frame();
        test_abort();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
